// File: rtl/sparc_ctrl_pkg.sv
// Shared encodings for the SPARC PC/nPC control path: CTI kinds, PC mux
// selects, Bicc condition constants and the delay-slot FSM state type.
package sparc_ctrl_pkg;

  localparam logic [1:0] CTI_BICC = 2'b00;
  localparam logic [1:0] CTI_CALL = 2'b01;
  localparam logic [1:0] CTI_JMPL = 2'b10;
  localparam logic [1:0] CTI_RSVD = 2'b11;

  localparam logic [1:0] PCSEL_NPC = 2'b00;
  localparam logic [1:0] PCSEL_TA  = 2'b01;
  localparam logic [1:0] PCSEL_ALU = 2'b10;

  localparam logic [3:0] COND_BA = 4'b1000;
  localparam logic [3:0] COND_BN = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DELAY = 2'b01,
    ANNUL = 2'b10
  } state_e;

endpackage

// File: rtl/cti_resolve.sv
// Combinational taken/annul decision for a CTI in ID, following the SPARC
// delayed-branch annul-bit rules.
module cti_resolve
  import sparc_ctrl_pkg::*;
(
  input  logic [1:0] i_cti_kind,
  input  logic [3:0] i_cond_code,
  input  logic       i_cond_true,
  input  logic       i_annul_bit,
  output logic       o_taken,
  output logic       o_annul
);

  logic w_is_bicc;
  logic w_is_ba;
  logic w_is_bn;

  // Non-Bicc transfers are unconditional; BA always, BN never, others on icc.
  always_comb begin
    w_is_bicc = (i_cti_kind == CTI_BICC);
    w_is_ba   = (i_cond_code == COND_BA);
    w_is_bn   = (i_cond_code == COND_BN);
    o_taken   = !w_is_bicc | w_is_ba | (!w_is_bn & i_cond_true);
    // a=1 annuls an untaken branch, and BA,a even though it is taken.
    o_annul   = w_is_bicc & i_annul_bit & (!o_taken | w_is_ba);
  end

endmodule

// File: rtl/delay_slot_ctrl.sv
// Control end of the PC/nPC register: resolves CTIs in ID, drives the PC mux
// select and load enable, tracks the delay slot and requests annulment.
// Optional build macro: DELAY_SLOT_DCTI_TRAP_EN adds illegal_dcti and turns a
// CTI in a delay slot into a flagged non-CTI instead of a DCTI couple.
module delay_slot_ctrl
  import sparc_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              cti_valid,
  input  logic [1:0]        cti_kind,
  input  logic [3:0]        cond_code,
  input  logic              cond_true,
  input  logic              annul_bit,
  output logic [1:0]        pc_mux_sel,
  output logic              pc_le,
  output logic              squash_if,
  output logic              in_delay_slot,
`ifdef DELAY_SLOT_DCTI_TRAP_EN
  output logic              illegal_dcti,
`endif
  output logic [PERF_W-1:0] taken_count
);

  state_e              r_state;
  state_e              w_state_next;
  logic [PERF_W-1:0]   r_taken_count;
  logic                w_taken;
  logic                w_annul;
  logic                w_accepted;
  logic                w_act;
  logic                w_count_inc;

  cti_resolve u_cti_resolve (
    .i_cti_kind  (cti_kind),
    .i_cond_code (cond_code),
    .i_cond_true (cond_true),
    .i_annul_bit (annul_bit),
    .o_taken     (w_taken),
    .o_annul     (w_annul)
  );

  // Acceptance gate; reset is folded in so outputs are quiet while it is held.
  always_comb begin
    w_accepted = cti_valid & !stall & !reset & (r_state != ANNUL) & (cti_kind != CTI_RSVD);
`ifdef DELAY_SLOT_DCTI_TRAP_EN
    illegal_dcti = w_accepted & (r_state == DELAY);
    w_act        = w_accepted & (r_state != DELAY);
`else
    w_act        = w_accepted;
`endif
    w_count_inc  = w_act & w_taken & (r_taken_count != {PERF_W{1'b1}});
  end

  // Zero-latency outputs from the current decision and state.
  always_comb begin
    pc_mux_sel = PCSEL_NPC;
    if (w_act & w_taken) begin
      pc_mux_sel = (cti_kind == CTI_JMPL) ? PCSEL_ALU : PCSEL_TA;
    end
    pc_le         = !reset & !stall;
    squash_if     = w_act & w_annul;
    in_delay_slot = (r_state == DELAY);
    taken_count   = r_taken_count;
  end

  // Next state; DELAY resolves a new CTI exactly like IDLE (DCTI couple).
  always_comb begin
    w_state_next = r_state;
    if (!stall) begin
      case (r_state)
        IDLE, DELAY: begin
          if (w_act & w_annul) begin
            w_state_next = ANNUL;
          end else if (w_act & w_taken) begin
            w_state_next = DELAY;
          end else begin
            w_state_next = IDLE;
          end
        end
        ANNUL:   w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Saturating taken-transfer counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taken_count <= '0;
    end else if (w_count_inc) begin
      r_taken_count <= r_taken_count + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_delay_slot_ctrl.sv
// Directed, table-driven bench for delay_slot_ctrl plus hand sequences for
// DCTI couples, asynchronous reset mid-transfer and counter saturation.
module tb_delay_slot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        cti_valid;
  logic [1:0]  cti_kind;
  logic [3:0]  cond_code;
  logic        cond_true;
  logic        annul_bit;

  logic [1:0]  sel_a, sel_b;
  logic        le_a, le_b, sq_a, sq_b, ds_a, ds_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;
`ifdef DELAY_SLOT_DCTI_TRAP_EN
  logic        ill_a, ill_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  delay_slot_ctrl #(.PERF_W(4)) u_dut4 (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .cti_valid     (cti_valid),
    .cti_kind      (cti_kind),
    .cond_code     (cond_code),
    .cond_true     (cond_true),
    .annul_bit     (annul_bit),
    .pc_mux_sel    (sel_a),
    .pc_le         (le_a),
    .squash_if     (sq_a),
    .in_delay_slot (ds_a),
`ifdef DELAY_SLOT_DCTI_TRAP_EN
    .illegal_dcti  (ill_a),
`endif
    .taken_count   (cnt_a)
  );

  delay_slot_ctrl u_dut16 (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .cti_valid     (cti_valid),
    .cti_kind      (cti_kind),
    .cond_code     (cond_code),
    .cond_true     (cond_true),
    .annul_bit     (annul_bit),
    .pc_mux_sel    (sel_b),
    .pc_le         (le_b),
    .squash_if     (sq_b),
    .in_delay_slot (ds_b),
`ifdef DELAY_SLOT_DCTI_TRAP_EN
    .illegal_dcti  (ill_b),
`endif
    .taken_count   (cnt_b)
  );

  typedef struct {
    logic       stall;
    logic       vld;
    logic [1:0] kind;
    logic [3:0] cond;
    logic       ct;
    logic       a;
    logic [1:0] sel;
    logic       le;
    logic       sq;
    logic       ds;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic vld, input logic [1:0] kind,
                     input logic [3:0] cond, input logic ct, input logic a,
                     input logic [1:0] sel, input logic le, input logic sq,
                     input logic ds, input logic [3:0] cnt);
    vec_t v;
    v.stall = st; v.vld = vld; v.kind = kind; v.cond = cond; v.ct = ct; v.a = a;
    v.sel = sel; v.le = le; v.sq = sq; v.ds = ds; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic vld, input logic [1:0] kind,
                       input logic [3:0] cond, input logic ct, input logic a);
    stall = st; cti_valid = vld; cti_kind = kind; cond_code = cond;
    cond_true = ct; annul_bit = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 2'b00, 4'h0, 0, 0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    drive(0, 0, 2'b00, 4'h0, 0, 0);
    reset = 1'b1;

    // Reset held for two cycles.
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst pc_le", le_a, 0);
    chk("rst sel", sel_a, 0);
    chk("rst cnt", cnt_a, 0);
    chk("rst ds", ds_a, 0);
    chk("rst squash", sq_a, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst pc_le", le_a, 1);
    chk("post-rst sel", sel_a, 0);
    chk("post-rst cnt", cnt_a, 0);
    chk("post-rst ds", ds_a, 0);
    next_cycle();

    //  st vld kind   cond   ct a   sel   le sq ds cnt
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 0, 0);  // idle
    add(0, 1, 2'b00, 4'h9, 1, 0, 2'b01, 1, 0, 0, 0);  // BNE taken
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 1, 1);  // delay slot
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 0, 1);
    add(0, 1, 2'b00, 4'h9, 0, 1, 2'b00, 1, 1, 0, 1);  // BNE,a untaken
    add(0, 1, 2'b01, 4'h0, 0, 0, 2'b00, 1, 0, 0, 1);  // CALL ignored in ANNUL
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 0, 1);
    add(0, 1, 2'b00, 4'h8, 0, 1, 2'b01, 1, 1, 0, 1);  // BA,a
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 0, 2);  // annulled slot
    add(0, 1, 2'b00, 4'h0, 1, 1, 2'b00, 1, 1, 0, 2);  // BN,a
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 0, 2);
    add(0, 1, 2'b00, 4'h9, 1, 1, 2'b01, 1, 0, 0, 2);  // BNE,a taken executes slot
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 1, 3);
    add(1, 1, 2'b10, 4'h0, 0, 0, 2'b00, 0, 0, 0, 3);  // JMPL stalled x3
    add(1, 1, 2'b10, 4'h0, 0, 0, 2'b00, 0, 0, 0, 3);
    add(1, 1, 2'b10, 4'h0, 0, 0, 2'b00, 0, 0, 0, 3);
    add(0, 1, 2'b10, 4'h0, 0, 0, 2'b10, 1, 0, 0, 3);  // JMPL released
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 1, 4);
    add(0, 1, 2'b01, 4'h0, 0, 0, 2'b01, 1, 0, 0, 4);  // CALL
    add(1, 0, 2'b00, 4'h0, 0, 0, 2'b00, 0, 0, 1, 5);  // stalled in DELAY
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 1, 5);
    add(0, 1, 2'b11, 4'h0, 1, 1, 2'b00, 1, 0, 0, 5);  // reserved kind
    add(0, 1, 2'b00, 4'h0, 1, 0, 2'b00, 1, 0, 0, 5);  // BN
    add(0, 0, 2'b00, 4'h0, 0, 0, 2'b00, 1, 0, 0, 5);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].vld, tbl[i].kind, tbl[i].cond, tbl[i].ct, tbl[i].a);
      @(negedge clk);
      chk($sformatf("row%0d sel", i), sel_a, tbl[i].sel);
      chk($sformatf("row%0d pc_le", i), le_a, tbl[i].le);
      chk($sformatf("row%0d squash", i), sq_a, tbl[i].sq);
      chk($sformatf("row%0d ds", i), ds_a, tbl[i].ds);
      chk($sformatf("row%0d cnt", i), cnt_a, tbl[i].cnt);
`ifdef DELAY_SLOT_DCTI_TRAP_EN
      chk($sformatf("row%0d illegal", i), ill_a, 0);
`endif
      next_cycle();
    end

    // CALL followed by CALL in its delay slot.
    do_reset();
    drive(0, 1, 2'b01, 4'h0, 0, 0);
    @(negedge clk);
    chk("dcti first sel", sel_a, 2'b01);
    next_cycle();
    @(negedge clk);
    chk("dcti second ds", ds_a, 1);
`ifdef DELAY_SLOT_DCTI_TRAP_EN
    chk("dcti second illegal", ill_a, 1);
    chk("dcti second sel", sel_a, 2'b00);
    chk("dcti second cnt", cnt_a, 1);
    next_cycle();
    drive(0, 0, 2'b00, 4'h0, 0, 0);
    @(negedge clk);
    chk("dcti after ds", ds_a, 0);
    chk("dcti after illegal", ill_a, 0);
    chk("dcti after cnt", cnt_a, 1);
`else
    chk("dcti second sel", sel_a, 2'b01);
    chk("dcti second cnt", cnt_a, 1);
    next_cycle();
    drive(0, 0, 2'b00, 4'h0, 0, 0);
    @(negedge clk);
    chk("dcti after ds", ds_a, 1);
    chk("dcti after cnt", cnt_a, 2);
`endif
    next_cycle();

    // Reset asserted mid-DELAY takes effect immediately.
    do_reset();
    drive(0, 1, 2'b01, 4'h0, 0, 0);
    next_cycle();
    drive(0, 0, 2'b00, 4'h0, 0, 0);
    chk("pre-abort ds", ds_a, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort ds", ds_a, 0);
    chk("abort cnt", cnt_a, 0);
    chk("abort pc_le", le_a, 0);
    next_cycle();
    reset = 1'b0;

    // Reset mid-ANNUL drops the pending annulment: next CALL is accepted.
    drive(0, 1, 2'b00, 4'h0, 0, 1);
    @(negedge clk);
    chk("bn,a squash", sq_a, 1);
    next_cycle();
    drive(0, 0, 2'b00, 4'h0, 0, 0);
    #2 reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(0, 1, 2'b01, 4'h0, 0, 0);
    @(negedge clk);
    chk("post-annul-abort sel", sel_a, 2'b01);
    next_cycle();

    // 17 taken CALLs saturate the 4-bit counter; the 16-bit one keeps counting.
    do_reset();
    for (int n = 0; n < 17; n++) begin
      drive(0, 1, 2'b01, 4'h0, 0, 0);
      next_cycle();
      drive(0, 0, 2'b00, 4'h0, 0, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("sat cnt4", cnt_a, 15);
    chk("sat cnt16", cnt_b, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_slot_ctrl.md
Name: delay_slot_ctrl

Overview:
- Control end of the PC/nPC register. It resolves SPARC control-transfer instructions (CTIs) in ID and drives the register's 2-bit mux select and load enable.
- Tracks the delayed-branch slot and requests annulment of the delay-slot instruction per SPARC annul-bit rules.
- Sits between decode/condition-evaluation and the PC_nPC_Register / IF-ID pipeline register.

Parameters:
- PERF_W, 16: width of the saturating taken-transfer counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard freeze; holds PC/nPC and FSM.
- cti_valid  in  1  ID holds a CTI this cycle.
- cti_kind  in  2  00 Bicc, 01 CALL, 10 JMPL/RETT, 11 reserved (treated as non-CTI).
- cond_code  in  4  Bicc cond field; 4'b1000 = BA, 4'b0000 = BN.
- cond_true  in  1  evaluated icc condition for cond_code.
- annul_bit  in  1  Bicc a-bit.
- pc_mux_sel  out  2  00 sequential nPC, 01 TA, 10 ALU_OUT.
- pc_le  out  1  PC/nPC load enable.
- squash_if  out  1  convert the IF/ID instruction to a NOP at the next edge.
- in_delay_slot  out  1  the ID instruction is an executing delay slot.
- taken_count  out  PERF_W  number of taken transfers, saturating.

Behaviour:
- Reset (asynchronous) forces the following, held while reset is high:
  - state = IDLE
  - taken_count = 0
  - pc_le = 0, pc_mux_sel = 00, squash_if = 0, in_delay_slot = 0
- accepted = cti_valid & !stall & (state != ANNUL) & (cti_kind != 11).
- Taken rule: taken = (cti_kind != 00) | (cond_code == BA) | ((cond_code != BN) & cond_true).
- Annul rule: annul = (cti_kind == 00) & annul_bit & (!taken | cond_code == BA).
- Outputs are combinational from inputs and state, with zero latency.
  - pc_mux_sel = 01 if accepted & taken & kind ∈ {Bicc, CALL}; 10 if accepted & taken & kind = JMPL; else 00.
  - pc_le = !stall when not in reset.
  - squash_if = accepted & annul.
  - in_delay_slot = (state == DELAY).
- FSM (advances only when !stall):
  - IDLE → ANNUL if accepted & annul.
  - IDLE → DELAY if accepted & taken & !annul.
  - IDLE → IDLE otherwise.
  - DELAY → IDLE after one non-stalled cycle. A CTI accepted in DELAY (DCTI couple) is resolved normally and may re-enter DELAY/ANNUL.
  - ANNUL → IDLE after one non-stalled cycle. cti_valid is ignored, since the instruction is squashed: no select, no count.
- Stall: state, counter and squash intent are held. pc_mux_sel is forced to 00 and pc_le to 0. The decision is re-evaluated on the first non-stalled cycle.
- taken_count increments by 1 on each accepted & taken edge. It saturates at all-ones with no wrap.
- Reset asserted mid-DELAY/ANNUL aborts the transfer immediately; the pending squash is dropped.
- BN with a=1 is not taken but annuls. BA with a=1 is taken and annuls. Conditional taken with a=1 executes the delay slot.

Optional Feature:
- Macro: DELAY_SLOT_DCTI_TRAP_EN.
- Defined:
  - Extra output illegal_dcti (1 bit).
  - A CTI accepted while state == DELAY pulses illegal_dcti for one cycle and is treated as a non-CTI: sel 00, no count, DELAY → IDLE.
- Undefined: DCTI couples are resolved normally as above, and the port is absent.

Decomposition:
- Package sparc_ctrl_pkg holds:
  - CTI kind codes (CTI_BICC, CTI_CALL, CTI_JMPL)
  - PC mux codes (PCSEL_NPC = 00, PCSEL_TA = 01, PCSEL_ALU = 10)
  - cond constants COND_BA, COND_BN
  - FSM state enum (IDLE, DELAY, ANNUL)
- One sub-module, cti_resolve: combinational taken/annul computation from kind, cond, cond_true and annul_bit. FSM and counter stay in the top.

Test Plan:
- Reset: reset = 1 for 2 cycles, then 0 → pc_le 0 → 1, sel 00, taken_count 0, in_delay_slot 0.
- Bicc BNE, cond_true = 1, a = 0 → same cycle sel = 01, squash_if = 0. Next cycle in_delay_slot = 1, then IDLE. taken_count = 1.
- Bicc BNE, cond_true = 0, a = 1 → sel = 00, squash_if = 1. Next cycle state ANNUL: a CTI presented there gives sel 00 and the count is unchanged.
- BA with a = 1 → sel = 01 and squash_if = 1 together. BN with a = 1 → sel = 00, squash_if = 1, count unchanged.
- JMPL with stall = 1 for 3 cycles, then 0 → sel 00 and pc_le 0 while stalled. On release sel = 10 for one cycle, then DELAY.
- Counter saturation with PERF_W = 4: 17 consecutive taken CALLs (each followed by a non-CTI slot) → taken_count stays 15.
- With DELAY_SLOT_DCTI_TRAP_EN: CALL then CALL in the slot → second cycle illegal_dcti = 1, sel 00, count = 1.
